// File: rtl/mux_scan_pkg.sv
// Shared mode/state encodings and a constant-width helper for the scanning mux.
package mux_scan_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic {
    S_MANUAL = 1'b0,
    S_SCAN   = 1'b1
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((longint'(1) << r) < longint'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/sel_debounce.sv
// Select-line debouncer: output follows the input only after CYCLES consecutive equal samples.
module sel_debounce
  import mux_scan_pkg::*;
#(
  parameter int unsigned WIDTH  = 2,
  parameter int unsigned CYCLES = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  localparam int unsigned CW = clog2(CYCLES + 1);

  logic [WIDTH-1:0] cand_q;
  logic [WIDTH-1:0] q_q;
  logic [CW-1:0]    run_q;
  logic [CW-1:0]    run_d;

  // run_d is the length of the equal-sample run including the current sample; saturates at CYCLES
  always_comb begin
    run_d = CW'(1);
    if (d_i == cand_q) begin
      run_d = (run_q == CW'(CYCLES)) ? run_q : run_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cand_q <= '0;
      run_q  <= '0;
      q_q    <= '0;
    end else begin
      cand_q <= d_i;
      run_q  <= run_d;
      if (run_d == CW'(CYCLES)) q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/mux_scan_n.sv
// N-channel registered mux with manual select and round-robin auto-scan.
// Define MUX_SEL_DEBOUNCE_EN to route sel_in through sel_debounce.
module mux_scan_n
  import mux_scan_pkg::*;
#(
  parameter  int unsigned CH         = 4,
  parameter  int unsigned W          = 8,
  parameter  int unsigned DWELL      = 1000,
  parameter  int unsigned DEB_CYCLES = 16,
  localparam int unsigned SEL_W      = (CH > 1) ? clog2(CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH*W-1:0]   din,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel_in,
  input  logic              en,
  output logic [W-1:0]      dout,
  output logic [SEL_W-1:0]  ch_idx,
  output logic              ch_chg
);

  localparam int unsigned CNT_W = clog2(DWELL) + 1;

  if (CH < 1 || W < 1 || DWELL < 1 || DEB_CYCLES < 1) begin : g_param_chk
    $error("mux_scan_n: CH, W, DWELL and DEB_CYCLES must all be >= 1");
  end

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [SEL_W-1:0] ch_idx_q;
  logic [SEL_W-1:0] idx_nxt;
  logic [W-1:0]     dout_q;
  logic [W-1:0]     dout_d;
  logic             ch_chg_q;
  logic [SEL_W-1:0] sel_eff;

`ifdef MUX_SEL_DEBOUNCE_EN
  sel_debounce #(
    .WIDTH  (SEL_W),
    .CYCLES (DEB_CYCLES)
  ) u_sel_debounce (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (sel_in),
    .q_o   (sel_eff)
  );
`else
  assign sel_eff = sel_in;
`endif

  // Counter is held at zero in manual so entering scan always starts a fresh dwell
  always_comb begin
    idx_nxt = ch_idx_q;
    cnt_d   = '0;
    unique case (state_q)
      S_MANUAL: begin
        if (32'(sel_eff) < CH) idx_nxt = sel_eff;
      end
      S_SCAN: begin
        cnt_d = cnt_q;
        if (en) begin
          if (cnt_q == CNT_W'(DWELL - 1)) begin
            cnt_d   = '0;
            idx_nxt = (ch_idx_q == SEL_W'(CH - 1)) ? '0 : ch_idx_q + SEL_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    dout_d = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      if (idx_nxt == SEL_W'(k)) dout_d = din[k*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_MANUAL;
      cnt_q    <= '0;
      ch_idx_q <= '0;
      dout_q   <= '0;
      ch_chg_q <= 1'b0;
    end else begin
      state_q  <= (mode == MODE_SCAN) ? S_SCAN : S_MANUAL;
      cnt_q    <= cnt_d;
      ch_idx_q <= idx_nxt;
      dout_q   <= dout_d;
      ch_chg_q <= (idx_nxt != ch_idx_q);
    end
  end

  assign dout   = dout_q;
  assign ch_idx = ch_idx_q;
  assign ch_chg = ch_chg_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Directed bench for mux_scan_n: reset, manual select, scan wrap, enable gating, mode/reset, DWELL=1.
module tb_mux_scan_n;

  localparam int unsigned CH = 4, W = 8, DWELL = 4, DEB = 16;
`ifdef MUX_SEL_DEBOUNCE_EN
  localparam int unsigned MAN_LAT = DEB + 1;
`else
  localparam int unsigned MAN_LAT = 1;
`endif
  localparam int unsigned LOAD = (MAN_LAT > 2) ? MAN_LAT : 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   din = '0;
  logic          mode = 1'b0;
  logic [1:0]    sel_in = '0;
  logic          en = 1'b0;
  logic [7:0]    dout;
  logic [1:0]    ch_idx;
  logic          ch_chg;

  logic [11:0]   din2 = 12'h321;
  logic          mode2 = 1'b0;
  logic [1:0]    sel2 = '0;
  logic          en2 = 1'b0;
  logic [3:0]    dout2;
  logic [1:0]    ch_idx2;
  logic          ch_chg2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_scan_n #(.CH(CH), .W(W), .DWELL(DWELL), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .din(din), .mode(mode), .sel_in(sel_in), .en(en),
    .dout(dout), .ch_idx(ch_idx), .ch_chg(ch_chg)
  );

  mux_scan_n #(.CH(3), .W(4), .DWELL(1), .DEB_CYCLES(DEB)) dut2 (
    .clk(clk), .rst(rst), .din(din2), .mode(mode2), .sel_in(sel2), .en(en2),
    .dout(dout2), .ch_idx(ch_idx2), .ch_chg(ch_chg2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; din = 32'hAABBCCDD; mode = 1'b0; sel_in = 2'd0; en = 1'b0;
    step(); step();
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", dout); end
    checks++; if (ch_idx !== 2'd0) begin errors++; $display("FAIL reset_ch got %0d exp 0", ch_idx); end
    checks++; if (ch_chg !== 1'b0) begin errors++; $display("FAIL reset_chg got %b exp 0", ch_chg); end
    rst = 1'b0;
    step();
    checks++; if (dout !== 8'hDD) begin errors++; $display("FAIL release_dout got %h exp dd", dout); end
    checks++; if (ch_chg !== 1'b0) begin errors++; $display("FAIL release_chg got %b exp 0", ch_chg); end
  endtask

  task automatic test_manual();
    logic [7:0] exp_d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    din = 32'h44332211;
    for (int i = 0; i < 4; i++) begin
      sel_in = 2'(i);
      repeat (MAN_LAT) step();
      checks++; if (dout !== exp_d[i]) begin errors++; $display("FAIL manual_dout sel %0d got %h exp %h", i, dout, exp_d[i]); end
      checks++; if (ch_idx !== 2'(i)) begin errors++; $display("FAIL manual_ch sel %0d got %0d exp %0d", i, ch_idx, i); end
      checks++; if (ch_chg !== (i != 0)) begin errors++; $display("FAIL manual_chg sel %0d got %b exp %b", i, ch_chg, i != 0); end
      step();
      checks++; if (ch_chg !== 1'b0) begin errors++; $display("FAIL manual_chg_clear sel %0d got %b exp 0", i, ch_chg); end
    end
  endtask

  task automatic test_scan_wrap();
    logic [1:0] e_ch;
    logic [7:0] e_d;
    sel_in = 2'd2;
    repeat (LOAD) step();
    checks++; if (ch_idx !== 2'd2) begin errors++; $display("FAIL scan_setup_ch got %0d exp 2", ch_idx); end
    mode = 1'b1; en = 1'b1;
    step();
    checks++; if (ch_idx !== 2'd2) begin errors++; $display("FAIL scan_entry_ch got %0d exp 2", ch_idx); end
    for (int j = 1; j <= 8; j++) begin
      step();
      e_ch = (j < 4) ? 2'd2 : (j < 8) ? 2'd3 : 2'd0;
      e_d  = (j < 4) ? 8'h33 : (j < 8) ? 8'h44 : 8'h11;
      checks++; if (ch_idx !== e_ch) begin errors++; $display("FAIL scan_ch cyc %0d got %0d exp %0d", j, ch_idx, e_ch); end
      checks++; if (dout !== e_d) begin errors++; $display("FAIL scan_dout cyc %0d got %h exp %h", j, dout, e_d); end
      checks++; if (ch_chg !== (j == 4 || j == 8)) begin errors++; $display("FAIL scan_chg cyc %0d got %b exp %b", j, ch_chg, (j == 4 || j == 8)); end
    end
  endtask

  task automatic test_enable_gating();
    logic [1:0] e_ch;
    for (int i = 0; i < 16; i++) begin
      en = (i % 2 == 0);
      step();
      e_ch = 2'((i >= 6) + (i >= 14));
      checks++; if (ch_idx !== e_ch) begin errors++; $display("FAIL gate_ch cyc %0d got %0d exp %0d", i, ch_idx, e_ch); end
    end
    checks++; if (dout !== 8'h33) begin errors++; $display("FAIL gate_dout got %h exp 33", dout); end
  endtask

  task automatic test_mode_reset();
    mode = 1'b0; en = 1'b0; sel_in = 2'd1;
    repeat (LOAD) step();
    mode = 1'b1; en = 1'b1;
    step(); step(); step();
    checks++; if (ch_idx !== 2'd1) begin errors++; $display("FAIL mid_scan_ch got %0d exp 1", ch_idx); end
    mode = 1'b0; sel_in = 2'd3;
    step();
    checks++; if (ch_idx !== 2'd1) begin errors++; $display("FAIL to_manual_hold got %0d exp 1", ch_idx); end
    repeat (LOAD - 2) step();
    step();
    checks++; if (ch_idx !== 2'd3) begin errors++; $display("FAIL to_manual_ch got %0d exp 3", ch_idx); end
    checks++; if (dout !== 8'h44) begin errors++; $display("FAIL to_manual_dout got %h exp 44", dout); end
    checks++; if (ch_chg !== 1'b1) begin errors++; $display("FAIL to_manual_chg got %b exp 1", ch_chg); end
    mode = 1'b1;
    step(); step(); step();
    rst = 1'b1; sel_in = 2'd0;
    step();
    checks++; if (ch_idx !== 2'd0) begin errors++; $display("FAIL midrst_ch got %0d exp 0", ch_idx); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL midrst_dout got %h exp 00", dout); end
    checks++; if (ch_chg !== 1'b0) begin errors++; $display("FAIL midrst_chg got %b exp 0", ch_chg); end
    rst = 1'b0;
    step();
    step(); step(); step();
    checks++; if (ch_idx !== 2'd0) begin errors++; $display("FAIL post_rst_dwell got %0d exp 0", ch_idx); end
    step();
    checks++; if (ch_idx !== 2'd1) begin errors++; $display("FAIL post_rst_adv got %0d exp 1", ch_idx); end
  endtask

`ifdef MUX_SEL_DEBOUNCE_EN
  task automatic test_debounce();
    mode = 1'b0; en = 1'b0; sel_in = 2'd0;
    repeat (LOAD) step();
    sel_in = 2'd2;
    repeat (5) step();
    sel_in = 2'd0;
    repeat (20) step();
    checks++; if (ch_idx !== 2'd0) begin errors++; $display("FAIL deb_glitch got %0d exp 0", ch_idx); end
    sel_in = 2'd2;
    repeat (DEB) step();
    checks++; if (ch_idx !== 2'd0) begin errors++; $display("FAIL deb_early got %0d exp 0", ch_idx); end
    step();
    checks++; if (ch_idx !== 2'd2) begin errors++; $display("FAIL deb_switch got %0d exp 2", ch_idx); end
  endtask
`endif

  task automatic test_dwell1();
    logic [1:0] e_ch [5] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    logic [3:0] e_d  [5] = '{4'h2, 4'h3, 4'h1, 4'h2, 4'h3};
    mode2 = 1'b1; en2 = 1'b1;
    step();
    checks++; if (ch_idx2 !== 2'd0) begin errors++; $display("FAIL d1_entry got %0d exp 0", ch_idx2); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (ch_idx2 !== e_ch[i]) begin errors++; $display("FAIL d1_ch cyc %0d got %0d exp %0d", i, ch_idx2, e_ch[i]); end
      checks++; if (dout2 !== e_d[i]) begin errors++; $display("FAIL d1_dout cyc %0d got %h exp %h", i, dout2, e_d[i]); end
      checks++; if (ch_chg2 !== 1'b1) begin errors++; $display("FAIL d1_chg cyc %0d got %b exp 1", i, ch_chg2); end
    end
    en2 = 1'b0;
    step(); step();
    checks++; if (ch_idx2 !== 2'd2) begin errors++; $display("FAIL d1_freeze got %0d exp 2", ch_idx2); end
    checks++; if (ch_chg2 !== 1'b0) begin errors++; $display("FAIL d1_freeze_chg got %b exp 0", ch_chg2); end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_scan_wrap();
    test_enable_gating();
    test_mode_reset();
`ifdef MUX_SEL_DEBOUNCE_EN
    test_debounce();
`endif
    test_dwell1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
